vote_logger: RTL
================

VOTE_LOGGER -- requirements
Module: vote_logger

Interface
REQ-001 Parameter NUM_CAND, default 4: number of candidates, one vote line each.
REQ-002 Parameter CNT_W, default 8: width of each per-candidate tally.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mode  input  1  0 = voting mode, 1 = display mode.
REQ-006 vote  input  NUM_CAND  one-cycle vote pulses, bit i = candidate i, one upstream button stage per bit.
REQ-007 arm  input  1  officer pulse enabling exactly one next ballot.
REQ-008 sel  input  $clog2(NUM_CAND)  candidate index shown in display mode.
REQ-009 ready  output  1  high while a ballot may be cast (state ARMED).
REQ-010 accepted  output  1  one-cycle pulse when a ballot is recorded.
REQ-011 rejected  output  1  one-cycle pulse when a ballot attempt is refused.
REQ-012 count_out  output  CNT_W  tally of candidate sel in display mode, else 0.
REQ-013 total_out  output  CNT_W+$clog2(NUM_CAND)  sum of all tallies in display mode, else 0.

Function
REQ-014 The FSM SHALL have two states: LOCKED and ARMED; ready = (state == ARMED), registered.
REQ-015 LOCKED -> ARMED SHALL occur when arm = 1 and mode = 0; arm in ARMED or with mode = 1 SHALL be ignored.
REQ-016 ARMED with exactly one vote bit i high and tally[i] below 2^CNT_W-1 SHALL increment tally[i] by 1, pulse accepted the next cycle, and move to LOCKED.
REQ-017 ARMED with two or more vote bits high SHALL change no tally, pulse rejected the next cycle, and remain ARMED.
REQ-018 ARMED with a single vote bit whose tally is saturated at 2^CNT_W-1 SHALL leave the tally unchanged, pulse rejected, and remain ARMED.
REQ-019 Any vote bit high in LOCKED SHALL change no tally and pulse rejected the next cycle.
REQ-020 mode = 1 SHALL force LOCKED on the next edge and take priority over any same-cycle vote or arm; such votes SHALL change no tally and raise neither pulse.
REQ-021 accepted and rejected SHALL never be high in the same cycle.
REQ-022 count_out and total_out SHALL be registered with 1-cycle latency from mode/sel/tally changes; 0 whenever mode = 0.
REQ-023 total_out SHALL be the exact, non-wrapping sum of all tallies.

Reset
REQ-024 reset low SHALL immediately clear all tallies, state to LOCKED, and ready, accepted, rejected, count_out, total_out to 0, regardless of clock.
REQ-025 Reset asserted mid-ballot SHALL discard the pending ballot; no pulse SHALL follow reset release.
REQ-026 After reset release, a fresh arm SHALL be needed before any vote is accepted.

Structure
REQ-027 A shared package SHALL hold the FSM state enumeration and the default NUM_CAND/CNT_W constants.
REQ-028 A single sub-module, vote_tally (one saturating CNT_W counter with increment enable and saturation flag), SHALL be instantiated NUM_CAND times; FSM, arbitration and display muxing SHALL live in vote_logger.

Verification
REQ-029 Reset, arm, vote = 4'b0100 -> tally[2] = 1, accepted one cycle later, ready drops; mode = 1, sel = 2 -> count_out = 1, total_out = 1 one cycle later.
REQ-030 Armed, vote = 4'b0011 -> rejected pulse, all tallies 0, ready stays 1; then vote = 4'b0001 -> tally[0] = 1, accepted.
REQ-031 No arm, vote = 4'b1000 -> rejected pulse, tally[3] = 0; arm while mode = 1 -> ready stays 0.
REQ-032 255 accepted ballots for candidate 1 (CNT_W = 8), then arm, vote = 4'b0010 -> rejected, tally[1] = 255, ready = 1.
REQ-033 Armed, mode = 1 and vote = 4'b0001 in the same cycle -> state LOCKED, tally[0] unchanged, no accepted and no rejected pulse.
REQ-034 After 3 ballots, reset low between clock edges -> all outputs 0 immediately; after release, mode = 1 -> total_out = 0.

Source files
------------

// File: rtl/vote_logger_pkg.sv
// Shared definitions for the vote logger: ballot FSM states and default sizing.
package vote_logger_pkg;

  typedef enum logic {
    LOCKED = 1'b0,
    ARMED  = 1'b1
  } state_t;

  localparam int NUM_CAND_DEF = 4;
  localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/vote_tally.sv
// One per-candidate tally: saturating up-counter with increment enable.
module vote_tally #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  assign sat = (count == '1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (inc && !sat)
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/vote_logger.sv
// Ballot logger: officer-armed single-vote FSM, per-candidate tallies and
// registered display of one tally plus the grand total.
module vote_logger
  import vote_logger_pkg::*;
#(
  parameter int NUM_CAND = NUM_CAND_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                mode,
  input  logic [NUM_CAND-1:0]                 vote,
  input  logic                                arm,
  input  logic [$clog2(NUM_CAND)-1:0]         sel,
  output logic                                ready,
  output logic                                accepted,
  output logic                                rejected,
  output logic [CNT_W-1:0]                    count_out,
  output logic [CNT_W+$clog2(NUM_CAND)-1:0]   total_out
);

  localparam int TOT_W = CNT_W + $clog2(NUM_CAND);

  state_t              state;
  logic [CNT_W-1:0]    tally [NUM_CAND];
  logic [NUM_CAND-1:0] sat;
  logic [NUM_CAND-1:0] inc;
  logic                onehot;
  logic                accept;
  logic [TOT_W-1:0]    sum;
  logic [CNT_W-1:0]    sel_tally;

  assign onehot = (vote != '0) && ((vote & (vote - NUM_CAND'(1))) == '0);
  // A single-bit ballot is only taken if that candidate's counter has headroom.
  assign accept = !mode && (state == ARMED) && onehot && ((vote & sat) == '0);
  assign inc    = accept ? vote : '0;
  assign ready  = (state == ARMED);

  for (genvar g = 0; g < NUM_CAND; g++) begin : g_tally
    vote_tally #(.CNT_W(CNT_W)) u_tally (
      .clock (clock),
      .reset (reset),
      .inc   (inc[g]),
      .count (tally[g]),
      .sat   (sat[g])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= LOCKED;
      accepted <= 1'b0;
      rejected <= 1'b0;
    end else begin
      accepted <= 1'b0;
      rejected <= 1'b0;
      if (mode) begin
        state <= LOCKED;
      end else begin
        case (state)
          LOCKED: begin
            rejected <= |vote;
            if (arm) state <= ARMED;
          end
          ARMED: begin
            if (accept) begin
              accepted <= 1'b1;
              state    <= LOCKED;
            end else if (|vote) begin
              rejected <= 1'b1;
            end
          end
          default: state <= LOCKED;
        endcase
      end
    end
  end

  always_comb begin
    sum       = '0;
    sel_tally = '0;
    for (int unsigned i = 0; i < NUM_CAND; i++) begin
      sum = sum + TOT_W'(tally[i]);
      if (int'(sel) == int'(i)) sel_tally = tally[i];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_out <= '0;
      total_out <= '0;
    end else begin
      count_out <= mode ? sel_tally : '0;
      total_out <= mode ? sum : '0;
    end
  end

endmodule
